// File: rtl/n_byte_memory.sv
// Small register file driven by a narrow command/data port: clear, saturating inc/dec, multi-beat write,
// read, clear-all, and an optional dec/repeat sequencer enabled by defining the REPEAT_EN macro.
module n_byte_memory #(
  parameter int NUM_REGS  = 4,
  parameter int MEM_WIDTH = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int IN_WIDTH   = 3 + ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [IN_WIDTH-1:0]           pc_in,
  output logic [MEM_WIDTH-1:0]          data_out,
  output logic                          out_valid,
  output logic                          int_wait,
  output logic                          busy,
  output logic                          err,
  output logic [NUM_REGS*MEM_WIDTH-1:0] data_view
);

  localparam int BEATS   = (MEM_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    OP_CLR    = 3'b000,
    OP_INC    = 3'b001,
    OP_DEC    = 3'b010,
    OP_WR     = 3'b011,
    OP_REP    = 3'b100,
    OP_RD     = 3'b101,
    OP_CLRALL = 3'b110,
    OP_INV    = 3'b111
  } op_t;

  op_t                    op;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [MEM_WIDTH-1:0]   regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [BEAT_CW-1:0]     beat_cnt;
  logic [MEM_WIDTH-1:0]   beat_word;

  assign op   = op_t'(pc_in[IN_WIDTH-1 -: 3]);
  assign addr = pc_in[ADDR_WIDTH-1:0];

  // Only the low MEM_WIDTH bits of the BEATS*IN_WIDTH shift chain ever reach a register,
  // so just those bits are kept; the bits above them would be shifted out unused.
  if (MEM_WIDTH > IN_WIDTH) begin : g_hold
    logic [MEM_WIDTH-IN_WIDTH-1:0] hold;
    assign beat_word = {hold, pc_in};
    always_ff @(posedge clk) begin
      if (rst) begin
        hold <= '0;
      end else if (en && int_wait) begin
        hold <= beat_word[MEM_WIDTH-IN_WIDTH-1:0];
      end
    end
  end else begin : g_direct
    assign beat_word = pc_in[MEM_WIDTH-1:0];
  end

  function automatic logic [MEM_WIDTH-1:0] step(input op_t o, input logic [MEM_WIDTH-1:0] v);
    case (o)
      OP_INC:  return (v == '1) ? v : v + 1'b1;
      OP_DEC:  return (v == '0) ? v : v - 1'b1;
      default: return '0;
    endcase
  endfunction

`ifdef REPEAT_EN
  typedef enum logic {S_IDLE, S_REPEAT} state_t;

  state_t                state;
  logic                  prev_valid;
  op_t                   prev_op;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [ADDR_WIDTH-1:0] cnt_addr;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      int_wait  <= 1'b0;
      err       <= 1'b0;
      wr_addr   <= '0;
      beat_cnt  <= '0;
`ifdef REPEAT_EN
      state      <= S_IDLE;
      busy       <= 1'b0;
      prev_valid <= 1'b0;
      prev_op    <= OP_CLR;
      prev_addr  <= '0;
      cnt_addr   <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef REPEAT_EN
      if (state == S_REPEAT) begin
        if (en) err <= 1'b1;
        case (prev_op)
          OP_CLR, OP_INC, OP_DEC: regs[prev_addr] <= step(prev_op, regs[prev_addr]);
          default: ;
        endcase
        regs[cnt_addr] <= regs[cnt_addr] - 1'b1;
        if (regs[cnt_addr] == MEM_WIDTH'(1)) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else
`endif
      if (en && int_wait) begin
        if (beat_cnt == BEAT_CW'(BEATS - 1)) begin
          regs[wr_addr] <= beat_word;
          int_wait      <= 1'b0;
        end
        beat_cnt <= beat_cnt + 1'b1;
      end else if (en) begin
        case (op)
          OP_CLR, OP_INC, OP_DEC: regs[addr] <= step(op, regs[addr]);
          OP_WR: begin
            int_wait <= 1'b1;
            wr_addr  <= addr;
            beat_cnt <= '0;
          end
          OP_RD: begin
            data_out  <= regs[addr];
            out_valid <= 1'b1;
          end
          OP_CLRALL: for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
`ifdef REPEAT_EN
          // Clear-all touches every register, the counter included, so it cannot be repeated.
          OP_REP: begin
            if (!prev_valid || prev_op == OP_WR || prev_op == OP_RD ||
                prev_op == OP_CLRALL || prev_addr == addr) begin
              err <= 1'b1;
            end else if (regs[addr] != '0) begin
              state    <= S_REPEAT;
              busy     <= 1'b1;
              cnt_addr <= addr;
            end
          end
`endif
          default: err <= 1'b1;
        endcase
`ifdef REPEAT_EN
        if (op != OP_REP && op != OP_INV) begin
          prev_valid <= 1'b1;
          prev_op    <= op;
          prev_addr  <= addr;
        end
`endif
      end
    end
  end

  always_comb begin
    data_view = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      data_view[k*MEM_WIDTH +: MEM_WIDTH] = regs[k];
    end
  end

endmodule

// File: tb/tb_n_byte_memory.sv
// Directed self-checking bench for n_byte_memory (NUM_REGS=4, MEM_WIDTH=8, IN_WIDTH=5, BEATS=2).
module tb_n_byte_memory;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  pc_in;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        int_wait;
  logic        busy;
  logic        err;
  logic [31:0] data_view;

  int checks = 0;
  int errors = 0;

  n_byte_memory #(.NUM_REGS(4), .MEM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_in(pc_in),
    .data_out(data_out), .out_valid(out_valid), .int_wait(int_wait),
    .busy(busy), .err(err), .data_view(data_view)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one strobe and returns at the next negedge.
  task automatic cmd(input logic [4:0] v);
    en = 1'b1;
    pc_in = v;
    @(negedge clk);
    en = 1'b0;
    pc_in = 5'b00000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    en = 1'b1;
    pc_in = 5'b11100;
    repeat (2) @(negedge clk);
    chk1("rst_err", err, 1'b0);
    chk("rst_view", data_view, 32'h0);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk1("rst_oval", out_valid, 1'b0);
    chk1("rst_iwait", int_wait, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    en = 1'b0;
    idle(1);

    // dec/repeat right after reset is an error in either build
    cmd(5'b10001);
    chk1("rep_after_rst_err", err, 1'b1);
    chk1("rep_after_rst_busy", busy, 1'b0);
    chk("rep_after_rst_view", data_view, 32'h0);
    do_reset();
    chk1("rst_clears_err", err, 1'b0);

    // write reg2 = 0xA5 then read it back
    cmd(5'b01110);
    chk1("wr_iwait0", int_wait, 1'b1);
    cmd(5'b00101);
    chk1("wr_iwait1", int_wait, 1'b1);
    chk("wr_partial_view", data_view, 32'h0);
    cmd(5'b00101);
    chk1("wr_iwait2", int_wait, 1'b0);
    chk("wr_view", data_view, 32'h00A50000);
    cmd(5'b10110);
    chk("rd_dout", 32'(data_out), 32'h000000A5);
    chk1("rd_oval", out_valid, 1'b1);
    idle(1);
    chk1("rd_oval_drop", out_valid, 1'b0);
    chk("rd_dout_hold", 32'(data_out), 32'h000000A5);

    // saturation on reg0
    cmd(5'b01100); cmd(5'b00111); cmd(5'b11111);
    chk("wr_ff_view", data_view, 32'h00A500FF);
    cmd(5'b00100);
    chk("inc_sat_view", data_view, 32'h00A500FF);
    cmd(5'b00000);
    chk("clr_view", data_view, 32'h00A50000);
    cmd(5'b01000);
    chk("dec_sat_view", data_view, 32'h00A50000);
    chk1("sat_no_err", err, 1'b0);
    cmd(5'b00101);
    chk("inc_view", data_view, 32'h00A50100);
    cmd(5'b01010);
    chk("dec_view", data_view, 32'h00A40100);

    // beats that look like commands are data only
    cmd(5'b01111); cmd(5'b11100); cmd(5'b11110);
    chk("wr_cmdlike_view", data_view, 32'h9EA40100);
    chk1("wr_cmdlike_err", err, 1'b0);

    // invalid opcode, sticky err
    cmd(5'b11100);
    chk1("inv_err", err, 1'b1);
    chk("inv_view", data_view, 32'h9EA40100);
    cmd(5'b10101);
    chk("rd1_dout", 32'(data_out), 32'h00000001);
    chk1("err_sticky", err, 1'b1);

    cmd(5'b11000);
    chk("clrall_view", data_view, 32'h0);

    // reset aborts a partial write
    do_reset();
    cmd(5'b01101); cmd(5'b00000); cmd(5'b00011);
    chk("wr_reg1_view", data_view, 32'h00000300);
    cmd(5'b01101); cmd(5'b11111);
    chk1("midwr_iwait", int_wait, 1'b1);
    do_reset();
    chk1("midwr_rst_iwait", int_wait, 1'b0);
    chk("midwr_rst_view", data_view, 32'h0);
    cmd(5'b00101);
    chk("post_abort_decoded", data_view, 32'h00000100);

`ifdef REPEAT_EN
    // repeat: reg1=3, reg0 inc then repeat 3x -> reg0=4
    do_reset();
    cmd(5'b01101); cmd(5'b00000); cmd(5'b00011);
    cmd(5'b00100);
    cmd(5'b10001);
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    chk("rep_busy_cycles", 32'(n), 32'd3);
    chk("rep_view", data_view, 32'h00000004);
    chk1("rep_no_err", err, 1'b0);

    // strobe during busy is ignored and flags err
    cmd(5'b01101); cmd(5'b00000); cmd(5'b00010);
    cmd(5'b00100);
    cmd(5'b10001);
    cmd(5'b11000);
    chk1("busy_strobe_err", err, 1'b1);
    chk1("busy_strobe_busy", busy, 1'b1);
    idle(1);
    chk1("busy_strobe_done", busy, 1'b0);
    chk("busy_strobe_view", data_view, 32'h00000007);

    // counter already zero -> no-op
    do_reset();
    cmd(5'b00100);
    cmd(5'b10001);
    chk1("rep_zero_busy", busy, 1'b0);
    chk1("rep_zero_err", err, 1'b0);
    chk("rep_zero_view", data_view, 32'h00000001);

    // reset during REPEAT
    cmd(5'b01101); cmd(5'b00000); cmd(5'b00011);
    cmd(5'b00100);
    cmd(5'b10001);
    idle(1);
    chk1("rep_mid_busy", busy, 1'b1);
    do_reset();
    chk1("rep_rst_busy", busy, 1'b0);
    chk("rep_rst_view", data_view, 32'h0);
    chk1("rep_rst_err", err, 1'b0);
    chk("rep_rst_dout", 32'(data_out), 32'h0);
    idle(2);
    chk("rep_rst_view_later", data_view, 32'h0);
`else
    // without the repeat engine, opcode 100 is invalid
    do_reset();
    cmd(5'b00100);
    cmd(5'b10001);
    chk1("norep_err", err, 1'b1);
    chk1("norep_busy", busy, 1'b0);
    chk("norep_view", data_view, 32'h00000001);
    idle(2);
    chk1("norep_busy_later", busy, 1'b0);
    chk("norep_view_later", data_view, 32'h00000001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
